// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD display converter.
package bin_to_bcd_pkg;

    localparam int BCD_WIDTH  = 8;
    localparam int BCD_DIGITS = 3;

    // Downstream seven-segment decoders show this code as all segments off.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: values 5..9 get +3 so the next shift
// carries into the following decimal digit. Plain 4-bit result, no carry out.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Combinational >=5 -> +3 correction
    always_comb begin
        q = d;
        if (d >= 4'd5)
            q = d + 4'd3;
    end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter, one shift per clock, start/busy/done
// handshake. Optional leading-zero blanking on the output is enabled by
// defining BIN2BCD_BLANK_EN; without it the raw digit register is driven out.
import bin_to_bcd_pkg::*;

module bin_to_bcd #(
    parameter int WIDTH  = BCD_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int CAT_W = 4*DIGITS + WIDTH;

    state_t                   state, nstate;
    logic [WIDTH-1:0]         shreg;
    logic [DIGITS-1:0][3:0]   scr;
    logic [DIGITS-1:0][3:0]   scr_adj;
    logic [DIGITS-1:0][3:0]   scr_sh;
    logic [WIDTH-1:0]         sh_sh;
    logic [CAT_W-1:0]         cat_sh;
    logic [CNT_W-1:0]         cnt;
    logic [DIGITS-1:0][3:0]   bcd_r;
    logic                     busy_nxt, done_nxt;

    // Per-digit correction, one instance per display digit
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (
            .d (scr[g]),
            .q (scr_adj[g])
        );
    end

    // Corrected scratch and shift register move left together as one word
    assign cat_sh = {scr_adj, shreg} << 1;
    assign scr_sh = cat_sh[CAT_W-1:WIDTH];
    assign sh_sh  = cat_sh[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nstate;
    end

    // Next-state logic; start outside IDLE is simply not looked at
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Output decode, registered below so busy/done come straight from flops
    always_comb begin
        busy_nxt = (nstate != IDLE);
        done_nxt = (state == SHIFT) && (nstate == DONE);
    end

    // Datapath: capture, shift, and result register updated only with done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            scr   <= '0;
            cnt   <= '0;
            bcd_r <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                shreg <= bin;
                scr   <= '0;
                cnt   <= CNT_W'(WIDTH);
            end else if (state == SHIFT) begin
                shreg <= sh_sh;
                scr   <= scr_sh;
                cnt   <= cnt - CNT_W'(1);
            end
            if (done_nxt)
                bcd_r <= scr_sh;
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0][3:0] bcd_v;
    logic                   lead;

    // Leading-zero blanking from the top digit down; ones digit always shown
    always_comb begin
        bcd_v = bcd_r;
        lead  = 1'b1;
        for (int k = DIGITS-1; k >= 1; k--) begin
            if (lead && bcd_r[k] == 4'd0)
                bcd_v[k] = BLANK_CODE;
            else
                lead = 1'b0;
        end
    end

    assign bcd = bcd_v;
`else
    assign bcd = bcd_r;
`endif

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: stimulus pushes expected digits, a
// negedge monitor pops on done and checks bcd holds between results.
module tb_bin_to_bcd;

    localparam int W = 8;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   bin;
    logic           busy, done;
    logic [4*D-1:0] bcd;

    logic [4*D-1:0] q[$];
    logic [4*D-1:0] last_exp;
    int             checks = 0;
    int             failures = 0;
    int             dones = 0;
    int             starts = 0;

    bin_to_bcd #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by division; blanked digits are those above
    // the value's magnitude.
    function automatic logic [4*D-1:0] exp_bcd(input int v);
        logic [4*D-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
`ifdef BIN2BCD_BLANK_EN
        begin
            int p;
            p = 1;
            for (int k = 0; k < D; k++) begin
                if (k > 0 && v < p) r[4*k +: 4] = 4'hF;
                p = p * 10;
            end
        end
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on done, otherwise bcd must hold the last result
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_done act=1 exp=0 t=%0t", $time);
                end else begin
                    last_exp = q.pop_front();
                    dones++;
                end
            end
            chk("bcd", 32'(bcd), 32'(last_exp));
        end
    end

    // One conversion starting at the next edge; optional extra start pulse
    // in cycle ic with value iv, which must be ignored.
    task automatic conv(input logic [W-1:0] v, input int ic, input logic [W-1:0] iv);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_before_start", 32'(busy), 32'd0);
        start = 1'b1;
        bin   = v;
        q.push_back(exp_bcd(int'(v)));
        starts++;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        for (int c = 1; c <= W; c++) begin
            bin = W'($urandom);
            if (c == ic) begin
                start = 1'b1;
                bin   = iv;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (c < W) chk("early_done", 32'(done), 32'd0);
            chk("busy_hold", 32'(busy), 32'd1);
        end
        chk("done_pulse", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("done_drop", 32'(done), 32'd0);
        chk("busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        last_exp = exp_bcd(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'(exp_bcd(0)));
        rst = 1'b0;
        @(posedge clk); #1;

        conv(8'd255, 0, 8'd0);
        conv(8'd0,   0, 8'd0);
        conv(8'd109, 0, 8'd0);
        conv(8'd7,   0, 8'd0);
        conv(8'd40,  0, 8'd0);
        conv(8'd200, 4, 8'd13);
        conv(8'd13,  0, 8'd0);

        // Abort a conversion of 99 in cycle 5
        start = 1'b1;
        bin   = 8'd99;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'(exp_bcd(0)));
        last_exp = exp_bcd(0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        conv(8'd99, 0, 8'd0);

        for (int i = 0; i < 256; i++) conv(W'(i), 0, 8'd0);
        for (int i = 0; i < 20; i++) conv(W'($urandom), int'($urandom_range(0, W)), W'($urandom));

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("done_count", 32'(dones), 32'(starts));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
